// File: rtl/modulation_segment_tx.sv
// Serial antipodal modulator: one NUM_SEG-bit frame in, one Q16.16 symbol stream out.
// Optional guard prefix of GUARD_LEN zero samples when MODULATION_GUARD_EN is defined.
module modulation_segment_tx #(
  parameter int NUM_SEG         = 10,
  parameter int SAMPLES_PER_SEG = 1,
  parameter int GUARD_LEN       = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NUM_SEG-1:0] input_bit,
  output logic [31:0]        sample_out,
  output logic [3:0]         seg_idx,
  output logic               valid,
  output logic               last,
  output logic               guard,
  output logic               busy
);

  localparam logic [31:0] PLUS     = 32'h0001_0000;
  localparam logic [31:0] MINUS    = 32'hFFFF_0000;
  localparam logic [7:0]  SPS_LAST = 8'(SAMPLES_PER_SEG - 1);
  localparam logic [3:0]  SEG_LAST = 4'(NUM_SEG - 1);

  if (NUM_SEG < 2 || NUM_SEG > 16 || SAMPLES_PER_SEG < 1 || SAMPLES_PER_SEG > 255 ||
      GUARD_LEN < 1 || GUARD_LEN > 15) begin : g_param_err
    $error("modulation_segment_tx: parameter out of legal range");
  end

  // Even segments use +1.0 as reference, odd ones -1.0; a zero bit selects the negated reference.
  function automatic logic [31:0] symbol(input logic [3:0] k, input logic b);
    return (b ^ k[0]) ? PLUS : MINUS;
  endfunction

`ifdef MODULATION_GUARD_EN
  localparam logic [3:0] GUARD_LAST = 4'(GUARD_LEN - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GUARD = 2'd2} state_t;
  logic [3:0] gcnt_q;
  logic       guard_q;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  state_t             state_q;
  logic [NUM_SEG-1:0] frame_q;
  logic [7:0]         sps_q;
  logic [3:0]         seg_q;
  logic [31:0]        sample_q;
  logic               valid_q;
  logic               last_q;

  logic [7:0]  nxt_sps_d;
  logic [3:0]  nxt_seg_d;
  logic        nxt_last_d;
  logic        end_d;
  logic [31:0] nxt_sym_d;

  // Position of the sample after the one currently on the outputs.
  always_comb begin
    nxt_sps_d = sps_q + 8'd1;
    nxt_seg_d = seg_q;
    if (sps_q == SPS_LAST) begin
      nxt_sps_d = 8'd0;
      nxt_seg_d = seg_q + 4'd1;
    end else begin
      nxt_sps_d = sps_q + 8'd1;
    end
    nxt_last_d = (nxt_seg_d == SEG_LAST) && (nxt_sps_d == SPS_LAST);
    end_d      = (seg_q == SEG_LAST) && (sps_q == SPS_LAST);
    nxt_sym_d  = symbol(nxt_seg_d, frame_q[nxt_seg_d]);
  end

  // Frame FSM; counters and outputs describe the sample being presented this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      sps_q    <= 8'd0;
      seg_q    <= 4'd0;
      sample_q <= 32'd0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
`ifdef MODULATION_GUARD_EN
      gcnt_q   <= 4'd0;
      guard_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            frame_q <= input_bit;
            valid_q <= 1'b1;
            sps_q   <= 8'd0;
            seg_q   <= 4'd0;
            last_q  <= 1'b0;
`ifdef MODULATION_GUARD_EN
            state_q  <= GUARD;
            gcnt_q   <= 4'd0;
            guard_q  <= 1'b1;
            sample_q <= 32'd0;
`else
            state_q  <= SEND;
            sample_q <= symbol(4'd0, input_bit[0]);
`endif
          end else begin
            valid_q  <= 1'b0;
            sample_q <= 32'd0;
            last_q   <= 1'b0;
          end
        end
`ifdef MODULATION_GUARD_EN
        GUARD: begin
          if (gcnt_q == GUARD_LAST) begin
            state_q  <= SEND;
            guard_q  <= 1'b0;
            sample_q <= symbol(4'd0, frame_q[0]);
          end else begin
            gcnt_q   <= gcnt_q + 4'd1;
          end
        end
`endif
        SEND: begin
          if (end_d) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            sample_q <= 32'd0;
            sps_q    <= 8'd0;
            seg_q    <= 4'd0;
            last_q   <= 1'b0;
          end else begin
            sps_q    <= nxt_sps_d;
            seg_q    <= nxt_seg_d;
            sample_q <= nxt_sym_d;
            last_q   <= nxt_last_d;
          end
        end
        default: begin
          state_q  <= IDLE;
          valid_q  <= 1'b0;
          sample_q <= 32'd0;
          sps_q    <= 8'd0;
          seg_q    <= 4'd0;
          last_q   <= 1'b0;
        end
      endcase
    end
  end

  assign sample_out = sample_q;
  assign seg_idx    = seg_q;
  assign valid      = valid_q;
  assign busy       = valid_q;
  assign last       = last_q;
`ifdef MODULATION_GUARD_EN
  assign guard      = guard_q;
`else
  assign guard      = 1'b0;
`endif

endmodule
